// File: rtl/sigma_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sigma_bus_pkg
// Brief    : Shared master-ID and arbiter-state types for the sigma bus.
// Revision : 1.0 - initial release
// ============================================================================
package sigma_bus_pkg;

    typedef enum logic [0:0] {
        M0 = 1'b0,
        M1 = 1'b1
    } master_id_e;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // M1 counts as the previous winner after reset, so M0 takes the first tie.
    localparam master_id_e c_reset_last_grant = M1;

    function automatic master_id_e other_master(input master_id_e id);
        return (id == M0) ? M1 : M0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sigma_id_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sigma_id_fifo
// Brief    : Order FIFO of master IDs for outstanding reads; push and pop may
//            occur together, including while full.
// Revision : 1.0 - initial release
// ============================================================================
module sigma_id_fifo
    import sigma_bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       arst_i,
    input  logic       push_i,
    input  master_id_e push_id_i,
    input  logic       pop_i,
    output master_id_e head_id_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int                 c_ptr_w      = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]   c_full_count = (c_ptr_w + 1)'(DEPTH);

    master_id_e         r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full_o    = (r_count == c_full_count);
    assign empty_o   = (r_count == '0);
    assign head_id_o = r_mem[r_rd_ptr];

    // A pop frees the head slot this cycle, so a push into a full FIFO is legal.
    assign w_do_pop  = pop_i && !empty_o;
    assign w_do_push = push_i && (!full_o || w_do_pop);

    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_id_i;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sigma_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sigma_bus_arbiter
// Brief    : Two-master (CPU / debug) round-robin arbiter onto one slave with
//            in-order read response routing and protocol-error flag.
// Revision : 1.0 - initial release
// ============================================================================
module sigma_bus_arbiter
    import sigma_bus_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int OUTST_DEPTH = 4
) (
    input  logic                clk_i,
    input  logic                arst_i,

    input  logic                m0_req_i,
    input  logic                m0_we_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W/8-1:0] m0_be_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    output logic                m0_ack_o,
    output logic                m0_resp_o,
    output logic [DATA_W-1:0]   m0_rdata_o,

    input  logic                m1_req_i,
    input  logic                m1_we_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W/8-1:0] m1_be_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    output logic                m1_ack_o,
    output logic                m1_resp_o,
    output logic [DATA_W-1:0]   m1_rdata_o,

    output logic                s_req_o,
    output logic                s_we_o,
    output logic [ADDR_W-1:0]   s_addr_o,
    output logic [DATA_W/8-1:0] s_be_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    input  logic                s_ack_i,
    input  logic                s_resp_i,
    input  logic [DATA_W-1:0]   s_rdata_i,

    output logic                err_o
);

    arb_state_e r_state;
    arb_state_e w_state_nxt;
    master_id_e r_owner;
    master_id_e w_owner_nxt;
    master_id_e r_last_grant;
    master_id_e w_last_grant_nxt;
    master_id_e w_grant;
    master_id_e w_head_id;
    logic       w_grant_valid;
    logic       w_read_blocked;
    logic       w_slave_req;
    logic       w_accept;
    logic       w_push;
    logic       w_pop;
    logic       w_fifo_full;
    logic       w_fifo_empty;
    logic       r_err;

    // Grant selection: the locked owner keeps the bus, otherwise round-robin.
    always_comb begin
        w_grant       = r_owner;
        w_grant_valid = 1'b0;
        if (r_state == ST_LOCKED) begin
            w_grant       = r_owner;
            w_grant_valid = (r_owner == M0) ? m0_req_i : m1_req_i;
        end else if (m0_req_i && m1_req_i) begin
            w_grant       = other_master(r_last_grant);
            w_grant_valid = 1'b1;
        end else if (m0_req_i) begin
            w_grant       = M0;
            w_grant_valid = 1'b1;
        end else if (m1_req_i) begin
            w_grant       = M1;
            w_grant_valid = 1'b1;
        end
    end

    assign s_we_o    = (w_grant == M0) ? m0_we_i    : m1_we_i;
    assign s_addr_o  = (w_grant == M0) ? m0_addr_i  : m1_addr_i;
    assign s_be_o    = (w_grant == M0) ? m0_be_i    : m1_be_i;
    assign s_wdata_o = (w_grant == M0) ? m0_wdata_i : m1_wdata_i;

    // A read may go out while full only if a response frees a slot this cycle.
    assign w_pop          = s_resp_i && !w_fifo_empty && !arst_i;
    assign w_read_blocked = !s_we_o && w_fifo_full && !w_pop;
    assign w_slave_req    = w_grant_valid && !w_read_blocked && !arst_i;
    assign w_accept       = w_slave_req && s_ack_i;
    assign w_push         = w_accept && !s_we_o;

    assign s_req_o   = w_slave_req;
    assign m0_ack_o  = w_accept && (w_grant == M0);
    assign m1_ack_o  = w_accept && (w_grant == M1);
    assign m0_resp_o = w_pop && (w_head_id == M0);
    assign m1_resp_o = w_pop && (w_head_id == M1);
    assign m0_rdata_o = s_rdata_i;
    assign m1_rdata_o = s_rdata_i;
    assign err_o     = r_err;

    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_grant_nxt = r_last_grant;
        if (w_accept) begin
            w_state_nxt      = ST_IDLE;
            w_last_grant_nxt = w_grant;
        end else if (w_grant_valid) begin
            w_state_nxt = ST_LOCKED;
            w_owner_nxt = w_grant;
        end else begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state      <= ST_IDLE;
            r_owner      <= M0;
            r_last_grant <= c_reset_last_grant;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_grant <= w_last_grant_nxt;
            if (s_resp_i && w_fifo_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    sigma_id_fifo #(
        .DEPTH (OUTST_DEPTH)
    ) u_id_fifo (
        .clk_i     (clk_i),
        .arst_i    (arst_i),
        .push_i    (w_push),
        .push_id_i (w_grant),
        .pop_i     (w_pop),
        .head_id_o (w_head_id),
        .full_o    (w_fifo_full),
        .empty_o   (w_fifo_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_sigma_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sigma_bus_arbiter
// Brief    : Directed self-checking bench with a read-response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sigma_bus_arbiter;

    logic        clk_i = 1'b0;
    logic        arst_i;
    logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
    logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
    logic [3:0]  m0_be_i, m1_be_i;
    logic        m0_ack_o, m0_resp_o, m1_ack_o, m1_resp_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        s_req_o, s_we_o;
    logic [31:0] s_addr_o, s_wdata_o;
    logic [3:0]  s_be_o;
    logic        s_ack_i, s_resp_i;
    logic [31:0] s_rdata_i;
    logic        err_o;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] slv_q[$];
    exp_t        mon_e;

    always #5 clk_i = ~clk_i;

    sigma_bus_arbiter #(
        .ADDR_W(32), .DATA_W(32), .OUTST_DEPTH(4)
    ) dut (
        .clk_i(clk_i), .arst_i(arst_i),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
        .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i),
        .m0_ack_o(m0_ack_o), .m0_resp_o(m0_resp_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
        .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i),
        .m1_ack_o(m1_ack_o), .m1_resp_o(m1_resp_o), .m1_rdata_o(m1_rdata_o),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
        .s_be_o(s_be_o), .s_wdata_o(s_wdata_o),
        .s_ack_i(s_ack_i), .s_resp_i(s_resp_i), .s_rdata_i(s_rdata_i),
        .err_o(err_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        m0_req_i = 0; m0_we_i = 0; m0_addr_i = 0; m0_be_i = 4'hf; m0_wdata_i = 0;
        m1_req_i = 0; m1_we_i = 0; m1_addr_i = 0; m1_be_i = 4'hf; m1_wdata_i = 0;
        s_ack_i = 0; s_resp_i = 0; s_rdata_i = 0;
    endtask

    task automatic pulse_reset();
        arst_i = 1;
        exp_q.delete();
        slv_q.delete();
        @(negedge clk_i);
        nxt();
        arst_i = 0;
    endtask

    // Every read response is matched against the oldest expected entry.
    always @(negedge clk_i) begin
        if (m0_resp_o || m1_resp_o) begin
            if (exp_q.size() == 0) begin
                chk("resp_unexpected", {m1_resp_o, m0_resp_o}, 2'b00);
            end else begin
                mon_e = exp_q.pop_front();
                chk("resp_route", {m1_resp_o, m0_resp_o}, mon_e.id ? 2'b10 : 2'b01);
                chk("resp_data", mon_e.id ? m1_rdata_o : m0_rdata_o, mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with requests present: outputs must stay quiet.
        idle();
        arst_i = 1; m0_req_i = 1; m1_req_i = 1; s_ack_i = 1; s_resp_i = 1;
        @(negedge clk_i);
        chk("rst_s_req", s_req_o, 0);
        chk("rst_acks", {m1_ack_o, m0_ack_o}, 0);
        chk("rst_resps", {m1_resp_o, m0_resp_o}, 0);
        chk("rst_err", err_o, 0);
        nxt();
        idle(); arst_i = 0;
        @(negedge clk_i);
        chk("post_rst_err", err_o, 0);

        // Single CPU read, ack same cycle, response two cycles later.
        nxt();
        m0_req_i = 1; m0_we_i = 0; m0_addr_i = 32'h10; s_ack_i = 1;
        exp_q.push_back('{id: 1'b0, data: 32'h12345678});
        slv_q.push_back(32'h12345678);
        @(negedge clk_i);
        chk("t1_s_req", s_req_o, 1);
        chk("t1_s_addr", s_addr_o, 32'h10);
        chk("t1_s_we", s_we_o, 0);
        chk("t1_s_be", s_be_o, 4'hf);
        chk("t1_acks", {m1_ack_o, m0_ack_o}, 2'b01);
        nxt(); idle();
        nxt(); s_resp_i = 1; s_rdata_i = slv_q.pop_front();
        @(negedge clk_i);
        chk("t1_m1_resp", m1_resp_o, 0);
        chk("t1_m0_resp", m0_resp_o, 1);
        nxt(); idle();

        // Both masters write every cycle: strict alternation starting at M0.
        pulse_reset();
        m0_req_i = 1; m0_we_i = 1; m0_addr_i = 32'h100; m0_wdata_i = 32'h0a;
        m1_req_i = 1; m1_we_i = 1; m1_addr_i = 32'h200; m1_wdata_i = 32'h0b;
        s_ack_i = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("rr_acks", {m1_ack_o, m0_ack_o}, (i % 2 == 0) ? 2'b01 : 2'b10);
            chk("rr_addr", s_addr_o, (i % 2 == 0) ? 32'h100 : 32'h200);
            nxt();
        end
        idle();

        // M1 write stalled five cycles while M0 waits behind it.
        for (int i = 0; i < 6; i++) begin
            m1_req_i = 1; m1_we_i = 1; m1_addr_i = 32'h80000000; m1_wdata_i = 32'hdeadbeef;
            m0_req_i = (i > 0); m0_we_i = 1; m0_addr_i = 32'h44; m0_wdata_i = 32'h55;
            s_ack_i = (i == 5);
            @(negedge clk_i);
            chk("lock_addr", s_addr_o, 32'h80000000);
            chk("lock_wdata", s_wdata_o, 32'hdeadbeef);
            chk("lock_acks", {m1_ack_o, m0_ack_o}, (i == 5) ? 2'b10 : 2'b00);
            nxt();
        end
        m1_req_i = 0; s_ack_i = 1;
        @(negedge clk_i);
        chk("lock_next_m0", {m1_ack_o, m0_ack_o}, 2'b01);
        chk("lock_next_addr", s_addr_o, 32'h44);
        nxt(); idle();

        // Fill the order FIFO with alternating reads.
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            idle();
            s_ack_i = 1;
            if (i % 2 == 0) begin
                m0_req_i = 1; m0_addr_i = 32'h1000 + 32'(i * 4);
            end else begin
                m1_req_i = 1; m1_addr_i = 32'h1000 + 32'(i * 4);
            end
            exp_q.push_back('{id: 1'(i % 2), data: 32'ha0000000 + 32'(i)});
            slv_q.push_back(32'ha0000000 + 32'(i));
            @(negedge clk_i);
            chk("fill_acks", {m1_ack_o, m0_ack_o}, (i % 2 == 0) ? 2'b01 : 2'b10);
            nxt();
        end
        // Fifth read wins the tie but is held off; the M1 write must wait.
        idle();
        m0_req_i = 1; m0_we_i = 0; m0_addr_i = 32'h2000;
        m1_req_i = 1; m1_we_i = 1; m1_addr_i = 32'h3000; m1_wdata_i = 32'h77;
        s_ack_i = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            chk("full_s_req", s_req_o, 0);
            chk("full_acks", {m1_ack_o, m0_ack_o}, 2'b00);
            nxt();
        end
        s_resp_i = 1; s_rdata_i = slv_q.pop_front();
        exp_q.push_back('{id: 1'b0, data: 32'hb0000000});
        slv_q.push_back(32'hb0000000);
        @(negedge clk_i);
        chk("pushpop_s_req", s_req_o, 1);
        chk("pushpop_acks", {m1_ack_o, m0_ack_o}, 2'b01);
        chk("pushpop_addr", s_addr_o, 32'h2000);
        nxt();
        s_resp_i = 0; m0_req_i = 0;
        @(negedge clk_i);
        chk("full_write_ack", {m1_ack_o, m0_ack_o}, 2'b10);
        chk("full_write_we", s_we_o, 1);
        nxt();
        // Occupancy is still four: another read is held off.
        m1_we_i = 0; m1_addr_i = 32'h4000;
        @(negedge clk_i);
        chk("still_full", s_req_o, 0);
        nxt();
        s_resp_i = 1; s_rdata_i = slv_q.pop_front();
        exp_q.push_back('{id: 1'b1, data: 32'hc0000000});
        slv_q.push_back(32'hc0000000);
        @(negedge clk_i);
        chk("still_full_accept", {m1_ack_o, m0_ack_o}, 2'b10);
        nxt();
        m1_req_i = 0;
        for (int i = 0; i < 4; i++) begin
            s_resp_i = 1; s_rdata_i = slv_q.pop_front();
            nxt();
        end
        idle();
        @(negedge clk_i);
        chk("drain_empty", exp_q.size(), 0);
        chk("drain_err", err_o, 0);

        // Response with nothing outstanding sets a sticky error.
        nxt();
        s_resp_i = 1; s_rdata_i = 32'hbad;
        @(negedge clk_i);
        chk("orphan_resps", {m1_resp_o, m0_resp_o}, 2'b00);
        nxt(); idle();
        @(negedge clk_i);
        chk("orphan_err", err_o, 1);
        nxt(); nxt(); nxt();
        @(negedge clk_i);
        chk("orphan_err_sticky", err_o, 1);
        pulse_reset();
        @(negedge clk_i);
        chk("err_cleared", err_o, 0);

        // Reset mid-transfer drops the outstanding read.
        nxt();
        m0_req_i = 1; m0_addr_i = 32'h50; s_ack_i = 1;
        @(negedge clk_i);
        chk("midrst_ack", m0_ack_o, 1);
        nxt(); idle();
        pulse_reset();
        s_resp_i = 1; s_rdata_i = 32'h99;
        @(negedge clk_i);
        chk("midrst_resps", {m1_resp_o, m0_resp_o}, 2'b00);
        nxt(); idle();
        @(negedge clk_i);
        chk("midrst_err", err_o, 1);
        chk("final_queue", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
